// File: rtl/counter_jk_sync_down_if.sv
// rtl/counter_jk_sync_down_if.sv - control/status bundle for one JK down-counter block
interface counter_jk_sync_down_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             load;
    logic             bin;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic             bout;

    modport master (
        output en, load, bin, din,
        input  j, k, q, qb, bout
    );

    modport slave (
        input  en, load, bin, din,
        output j, k, q, qb, bout
    );
endinterface

// File: rtl/counter_jk_sync_down.sv
// rtl/counter_jk_sync_down.sv - cascadable down counter built from per-bit JK stages
module counter_jk_sync_down #(
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   clearb,
    counter_jk_sync_down_if.slave  bus
);
    logic             cen;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] q;

    assign cen = bus.en & bus.bin;

    // A bit toggles on a decrement only when every lower bit is already 0.
    always_comb begin
        logic run;
        run = 1'b1;
        t   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            t[i] = run;
            run  = run & ~q[i];
        end
    end

    // Load drives set/reset directly, so din is never looked at unless load=1.
    always_comb begin
        j = '0;
        k = '0;
        if (bus.load) begin
            j = bus.din;
            k = ~bus.din;
        end else if (cen) begin
            j = t;
            k = t;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        always_ff @(posedge clk or negedge clearb) begin
            if (!clearb) begin
                q[i] <= 1'b0;
            end else begin
                case ({j[i], k[i]})
                    2'b01:   q[i] <= 1'b0;
                    2'b10:   q[i] <= 1'b1;
                    2'b11:   q[i] <= ~q[i];
                    default: q[i] <= q[i];
                endcase
            end
        end
    end

    assign bus.j    = j;
    assign bus.k    = k;
    assign bus.q    = q;
    assign bus.qb   = ~q;
    assign bus.bout = cen & ~|q;
endmodule

// File: tb/tb_counter_jk_sync_down.sv
// tb/tb_counter_jk_sync_down.sv - randomized and directed bench for counter_jk_sync_down
module tb_counter_jk_sync_down;
    localparam int W = 4;
    localparam logic [W-1:0] M = {W{1'b1}};

    logic clk = 1'b0;
    logic clearb = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    logic [W-1:0] mq;

    counter_jk_sync_down_if #(.WIDTH(W)) lo_if ();
    counter_jk_sync_down_if #(.WIDTH(W)) hi_if ();

    counter_jk_sync_down #(.WIDTH(W)) dut    (.clk(clk), .clearb(clearb), .bus(lo_if.slave));
    counter_jk_sync_down #(.WIDTH(W)) dut_hi (.clk(clk), .clearb(clearb), .bus(hi_if.slave));

    assign hi_if.en  = lo_if.en;
    assign hi_if.bin = lo_if.bout;

    always #5 clk = ~clk;

    // Decrement flips exactly the bits that differ between q and q-1.
    function automatic logic [W-1:0] exp_j(logic [W-1:0] q, logic l, logic e, logic b, logic [W-1:0] d);
        if (l) return d;
        if (e & b) return q ^ (q - 1'b1);
        return '0;
    endfunction

    function automatic logic [W-1:0] exp_k(logic [W-1:0] q, logic l, logic e, logic b, logic [W-1:0] d);
        if (l) return ~d;
        if (e & b) return q ^ (q - 1'b1);
        return '0;
    endfunction

    function automatic logic [W-1:0] model_next(logic [W-1:0] q, logic l, logic e, logic b, logic [W-1:0] d);
        if (l) return d;
        if (e & b) return q - 1'b1;
        return q;
    endfunction

    task automatic drive(input logic l, input logic e, input logic b, input logic [W-1:0] d);
        @(negedge clk);
        lo_if.load = l;
        lo_if.en   = e;
        lo_if.bin  = b;
        lo_if.din  = d;
        hi_if.load = 1'b0;
        #1;
    endtask

    task automatic clock_model;
        @(posedge clk);
        mq = model_next(mq, lo_if.load, lo_if.en, lo_if.bin, lo_if.din);
        #1;
    endtask

    task automatic test_reset;
        clearb = 1'b0;
        lo_if.load = 1'b0; lo_if.en = 1'b1; lo_if.bin = 1'b1; lo_if.din = '0;
        hi_if.load = 1'b0; hi_if.din = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (lo_if.q !== 4'b0000) begin
                miscompares++; $display("FAIL reset_q got=%b exp=0000", lo_if.q);
            end
            vectors++;
            if (lo_if.qb !== 4'b1111) begin
                miscompares++; $display("FAIL reset_qb got=%b exp=1111", lo_if.qb);
            end
            vectors++;
            if (lo_if.bout !== 1'b1) begin
                miscompares++; $display("FAIL reset_bout got=%b exp=1", lo_if.bout);
            end
        end
        @(negedge clk);
        clearb = 1'b1;
        mq = '0;
        clock_model();
        vectors++;
        if (lo_if.q !== 4'b1111 || mq !== 4'b1111) begin
            miscompares++; $display("FAIL reset_release_q got=%b exp=1111", lo_if.q);
        end
    endtask

    task automatic test_countdown;
        drive(1'b1, 1'b0, 1'b1, 4'b1010);
        vectors++;
        if (lo_if.j !== 4'b1010 || lo_if.k !== 4'b0101) begin
            miscompares++; $display("FAIL load_jk got j=%b k=%b exp j=1010 k=0101", lo_if.j, lo_if.k);
        end
        clock_model();
        for (int i = 0; i < 11; i++) begin
            drive(1'b0, 1'b1, 1'b1, 4'b0000);
            vectors++;
            if (lo_if.bout !== (mq == 0)) begin
                miscompares++; $display("FAIL countdown_bout step=%0d got=%b exp=%b", i, lo_if.bout, (mq == 0));
            end
            vectors++;
            if (lo_if.j !== exp_j(mq, 1'b0, 1'b1, 1'b1, 4'b0)) begin
                miscompares++; $display("FAIL countdown_j step=%0d got=%b exp=%b", i, lo_if.j, exp_j(mq, 1'b0, 1'b1, 1'b1, 4'b0));
            end
            clock_model();
            vectors++;
            if (lo_if.q !== mq) begin
                miscompares++; $display("FAIL countdown_q step=%0d got=%b exp=%b", i, lo_if.q, mq);
            end
        end
        vectors++;
        if (lo_if.q !== 4'b1111) begin
            miscompares++; $display("FAIL countdown_wrap got=%b exp=1111", lo_if.q);
        end
    endtask

    task automatic test_excitation;
        drive(1'b1, 1'b0, 1'b1, 4'b1000);
        clock_model();
        drive(1'b0, 1'b1, 1'b1, 4'b0000);
        vectors++;
        if (lo_if.j !== 4'b1111 || lo_if.k !== 4'b1111) begin
            miscompares++; $display("FAIL excite_1000 got j=%b k=%b exp 1111", lo_if.j, lo_if.k);
        end
        drive(1'b1, 1'b0, 1'b1, 4'b0110);
        clock_model();
        drive(1'b0, 1'b1, 1'b1, 4'b0000);
        vectors++;
        if (lo_if.j !== 4'b0011 || lo_if.k !== 4'b0011) begin
            miscompares++; $display("FAIL excite_0110 got j=%b k=%b exp 0011", lo_if.j, lo_if.k);
        end
        drive(1'b0, 1'b0, 1'b1, 4'b0000);
        vectors++;
        if (lo_if.j !== 4'b0000 || lo_if.k !== 4'b0000) begin
            miscompares++; $display("FAIL excite_hold got j=%b k=%b exp 0000", lo_if.j, lo_if.k);
        end
        clock_model();
    endtask

    task automatic test_load_priority;
        drive(1'b1, 1'b0, 1'b1, 4'b0101);
        clock_model();
        drive(1'b1, 1'b1, 1'b1, 4'b1100);
        vectors++;
        if (lo_if.j !== 4'b1100 || lo_if.k !== 4'b0011 || lo_if.bout !== 1'b0) begin
            miscompares++; $display("FAIL loadprio_comb got j=%b k=%b bout=%b exp j=1100 k=0011 bout=0", lo_if.j, lo_if.k, lo_if.bout);
        end
        clock_model();
        vectors++;
        if (lo_if.q !== 4'b1100) begin
            miscompares++; $display("FAIL loadprio_q got=%b exp=1100", lo_if.q);
        end
    endtask

    task automatic test_hold_borrow;
        drive(1'b1, 1'b0, 1'b1, 4'b0000);
        clock_model();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 4'b0000);
            vectors++;
            if (lo_if.bout !== 1'b0) begin
                miscompares++; $display("FAIL hold_bout step=%0d got=%b exp=0", i, lo_if.bout);
            end
            clock_model();
            vectors++;
            if (lo_if.q !== 4'b0000) begin
                miscompares++; $display("FAIL hold_q step=%0d got=%b exp=0000", i, lo_if.q);
            end
        end
        drive(1'b0, 1'b1, 1'b1, 4'b0000);
        vectors++;
        if (lo_if.bout !== 1'b1) begin
            miscompares++; $display("FAIL resume_bout got=%b exp=1", lo_if.bout);
        end
        clock_model();
        vectors++;
        if (lo_if.q !== 4'b1111) begin
            miscompares++; $display("FAIL resume_q got=%b exp=1111", lo_if.q);
        end
    endtask

    task automatic test_async_clear;
        drive(1'b1, 1'b0, 1'b1, 4'b0111);
        clock_model();
        drive(1'b0, 1'b1, 1'b1, 4'b0000);
        #1;
        clearb = 1'b0;
        #1;
        vectors++;
        if (lo_if.q !== 4'b0000 || lo_if.qb !== 4'b1111) begin
            miscompares++; $display("FAIL async_clear got q=%b qb=%b exp q=0000 qb=1111", lo_if.q, lo_if.qb);
        end
        @(posedge clk); #1;
        vectors++;
        if (lo_if.q !== 4'b0000) begin
            miscompares++; $display("FAIL clear_edge got=%b exp=0000", lo_if.q);
        end
        @(negedge clk);
        clearb = 1'b1;
        mq = '0;
    endtask

    task automatic test_cascade;
        @(negedge clk);
        lo_if.load = 1'b1; lo_if.en = 1'b0; lo_if.bin = 1'b1; lo_if.din = 4'h0;
        hi_if.load = 1'b1; hi_if.din = 4'h1;
        @(posedge clk); #1;
        mq = 4'h0;
        drive(1'b0, 1'b1, 1'b1, 4'b0000);
        clock_model();
        vectors++;
        if ({hi_if.q, lo_if.q} !== 8'h0F) begin
            miscompares++; $display("FAIL cascade got=%h exp=0f", {hi_if.q, lo_if.q});
        end
    endtask

    task automatic test_random;
        logic l, e, b;
        logic [W-1:0] d;
        for (int i = 0; i < 300; i++) begin
            l = ($urandom_range(0, 7) == 0);
            e = ($urandom_range(0, 3) != 0);
            b = ($urandom_range(0, 3) != 0);
            d = W'($urandom);
            drive(l, e, b, d);
            if (!l) begin
                lo_if.din = 'x;
                #1;
            end
            vectors++;
            if (lo_if.j !== exp_j(mq, l, e, b, d) || lo_if.k !== exp_k(mq, l, e, b, d)) begin
                miscompares++; $display("FAIL rand_jk step=%0d got j=%b k=%b exp j=%b k=%b", i, lo_if.j, lo_if.k, exp_j(mq, l, e, b, d), exp_k(mq, l, e, b, d));
            end
            vectors++;
            if (lo_if.bout !== (e & b & (mq == 0))) begin
                miscompares++; $display("FAIL rand_bout step=%0d got=%b exp=%b", i, lo_if.bout, (e & b & (mq == 0)));
            end
            @(posedge clk);
            mq = model_next(mq, l, e, b, d);
            #1;
            vectors++;
            if (lo_if.q !== mq || lo_if.qb !== ~mq) begin
                miscompares++; $display("FAIL rand_q step=%0d got q=%b qb=%b exp q=%b", i, lo_if.q, lo_if.qb, mq);
            end
        end
    endtask

    initial begin
        mq = '0;
        test_reset();
        test_countdown();
        test_excitation();
        test_load_priority();
        test_hold_borrow();
        test_async_clear();
        test_cascade();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/counter_jk_sync_down.md
Name: counter_jk_sync_down

Overview:
- Synchronous down counter, the counting-direction complement of the team's JK synchronous up counter.
- Built from per-bit JK flip-flop stages. Each stage's J/K drive is exported so the excitation logic can be checked directly.
- Adds synchronous parallel load, count enable and a borrow (terminal-count) output so several blocks cascade into wider down counters.
- Used as a countdown/timer element next to the up counter in the lab datapath.

Parameters:
- WIDTH, 4, number of counter bits (JK stages); legal range 2..16.

Ports:
- clk  input  1  rising-edge clock; all JK stages share it.
- clearb  input  1  asynchronous active-low reset; forces every stage to q=0.
- en  input  1  count enable; when high and load low, decrement by 1 per clk edge.
- load  input  1  synchronous parallel load; overrides en.
- din  input  WIDTH  value written into q on a load edge.
- bin  input  1  borrow-in from the next-lower cascaded block; ANDed with en (tie 1 when standalone).
- j  output  WIDTH  J input presented to each stage (combinational, observable).
- k  output  WIDTH  K input presented to each stage (combinational, observable).
- q  output  WIDTH  counter state.
- qb  output  WIDTH  bitwise complement of q.
- bout  output  1  borrow-out: en & bin & (q == 0); combinational, for cascading.

Behaviour:
- Each bit is a JK flip-flop with the standard JK function:
  - J=0,K=0: hold.
  - J=1,K=0: set.
  - J=0,K=1: reset.
  - J=1,K=1: toggle.
- The flip-flop updates on the rising clk edge. Its clearb is asynchronous.
- Reset: while clearb=0, q=0 and qb={WIDTH{1}} immediately, independent of clk. After reset, bout=en&bin, because q==0.
- Release of clearb is synchronous in effect: the first state change occurs on the first rising clk edge with clearb=1.
- Excitation, priority load > count > hold:
  - load=1: j[i]=din[i], k[i]=~din[i]. Next q=din, regardless of en/bin.
  - load=0, cen=en&bin=1: j[i]=k[i]=t[i], where t[0]=1 and t[i]=t[i-1]&~q[i-1] (bit i toggles when all lower bits are 0). Next q=q-1 mod 2^WIDTH.
  - load=0, cen=0: j=k=0, so q holds.
- Latency: one clk edge from the load/en sample to the new q. j, k and bout are combinational from q, din, load, en and bin within the same cycle.
- Wrap: q=0 with cen=1 gives q={WIDTH{1}} on the next edge. bout is high during the cycle in which q=0 and cen=1.
- No stop-at-zero mode. Cascading: a higher block's bin connects to the lower block's bout, and all blocks share clk/clearb/en.
- Simultaneous load and en: load wins; bout still reflects the current q.
- clearb asserted mid-count or mid-load: q goes to 0 asynchronously. A clk edge while clearb=0 has no effect.
- qb equals ~q at all times, including during reset.
- X on din is permitted when load=0 and must not propagate to q.

Test Plan:
- Reset: hold clearb=0 with en=1 across 3 clk edges -> q=0000, qb=1111 throughout. Release, then one en edge -> q=1111.
- Full countdown: load din=1010, then en=1,bin=1 for 11 edges -> q sequence 1010,1001,...,0001,0000,1111. bout=1 only in the q=0000 cycle.
- Excitation check at q=1000 with en=1 -> j=k=1111. At q=0110 -> j=k=0011. With en=0 -> j=k=0000.
- Load priority: q=0101, load=1,en=1,din=1100 -> next q=1100 (not 0100). During load, j=1100 and k=0011.
- Hold/borrow gating: en=1,bin=0 for 4 edges -> q unchanged and bout=0. Then bin=1 -> decrement resumes.
- Async clear mid-count: q=0111, drop clearb between edges -> q=0000 before the next edge. Two cascaded 4-bit blocks loaded with 0x10, one en edge -> 0x0F.
